// File: rtl/mux_2_1_arbiter_pkg.sv
// Shared definitions for the two-requester arbiter: state encodings and mux select constants.
package mux_2_1_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_2_1.sv
// Plain 2:1 multiplexer: y follows A when Sel=0 and B when Sel=1.
module mux_2_1 (
    input  logic A,
    input  logic B,
    input  logic Sel,
    output logic y
);

    assign y = Sel ? B : A;

endmodule

// File: rtl/mux_2_1_arbiter.sv
// Two-requester arbiter with a bounded ownership burst that steers a shared mux_2_1.
// Define MUX_ARB_FIXED_PRIO_EN for fixed A priority; round-robin otherwise.
module mux_2_1_arbiter
    import mux_2_1_arbiter_pkg::*;
#(
    parameter  int unsigned MAX_BURST = 4,
    localparam int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             a_in,
    input  logic             b_in,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic             y_out,
    output logic             busy,
    output logic [CNT_W-1:0] burst_cnt
);

    state_t state;
    state_t state_nxt;
    logic   at_limit;

`ifndef MUX_ARB_FIXED_PRIO_EN
    logic   last_owner;
`endif

    assign at_limit = (burst_cnt == CNT_W'(MAX_BURST - 1));
    assign busy     = gnt_a | gnt_b;

    // Next-state decision; the unused 2'b11 encoding falls back to IDLE.
    always_comb begin
        state_nxt = IDLE;
        case (state)
`ifdef MUX_ARB_FIXED_PRIO_EN
            IDLE: begin
                if (req_a)      state_nxt = OWN_A;
                else if (req_b) state_nxt = OWN_B;
                else            state_nxt = IDLE;
            end
            OWN_A: begin
                if (!req_a)                 state_nxt = req_b ? OWN_B : IDLE;
                else if (at_limit && req_b) state_nxt = OWN_B;
                else                        state_nxt = OWN_A;
            end
            OWN_B: begin
                if (req_a)       state_nxt = OWN_A;
                else if (!req_b) state_nxt = IDLE;
                else             state_nxt = OWN_B;
            end
`else
            IDLE: begin
                if (req_a && (!req_b || last_owner == SEL_B)) state_nxt = OWN_A;
                else if (req_b)                                state_nxt = OWN_B;
                else                                           state_nxt = IDLE;
            end
            OWN_A: begin
                if (!req_a)                 state_nxt = req_b ? OWN_B : IDLE;
                else if (at_limit && req_b) state_nxt = OWN_B;
                else                        state_nxt = OWN_A;
            end
            OWN_B: begin
                if (!req_b)                 state_nxt = req_a ? OWN_A : IDLE;
                else if (at_limit && req_a) state_nxt = OWN_A;
                else                        state_nxt = OWN_B;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Grants, select and burst counter all follow the chosen next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            sel        <= SEL_A;
            burst_cnt  <= '0;
`ifndef MUX_ARB_FIXED_PRIO_EN
            last_owner <= SEL_B;
`endif
        end else begin
            state <= state_nxt;
            gnt_a <= (state_nxt == OWN_A);
            gnt_b <= (state_nxt == OWN_B);
            if (state_nxt == OWN_A)      sel <= SEL_A;
            else if (state_nxt == OWN_B) sel <= SEL_B;

            // A new ownership, an idle cycle or a burst at its limit restarts the count.
            if (state_nxt != state || state_nxt == IDLE || at_limit)
                burst_cnt <= '0;
            else
                burst_cnt <= burst_cnt + CNT_W'(1);

`ifndef MUX_ARB_FIXED_PRIO_EN
            if (state_nxt == OWN_A)      last_owner <= SEL_A;
            else if (state_nxt == OWN_B) last_owner <= SEL_B;
`endif
        end
    end

    mux_2_1 u_mux (
        .A   (a_in),
        .B   (b_in),
        .Sel (sel),
        .y   (y_out)
    );

endmodule

// File: tb/tb_mux_2_1_arbiter.sv
// Directed scoreboard bench for mux_2_1_arbiter with MAX_BURST=4; honours MUX_ARB_FIXED_PRIO_EN.
module tb_mux_2_1_arbiter;

    localparam int unsigned MAX_BURST = 4;
    localparam int unsigned CNT_W     = $clog2(MAX_BURST + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             req_a;
    logic             req_b;
    logic             a_in;
    logic             b_in;
    logic             gnt_a;
    logic             gnt_b;
    logic             sel;
    logic             y_out;
    logic             busy;
    logic [CNT_W-1:0] burst_cnt;

    typedef struct {
        string            tag;
        logic             ga;
        logic             gb;
        logic             sel;
        logic [CNT_W-1:0] cnt;
        logic             y;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    logic started    = 1'b0;

    mux_2_1_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .req_b     (req_b),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .sel       (sel),
        .y_out     (y_out),
        .busy      (busy),
        .burst_cnt (burst_cnt)
    );

    always #5 clk = ~clk;

    // Structural invariants sampled mid-cycle once reset has been seen.
    always @(negedge clk) begin
        if (started) begin
            compared++;
            assert (!(gnt_a && gnt_b) && !(gnt_a && sel) && !(gnt_b && !sel)
                    && busy === (gnt_a | gnt_b))
            else begin
                mismatched++;
                $error("FAIL invariant: observed ga=%b gb=%b sel=%b busy=%b, required exclusive grants matching sel and busy",
                       gnt_a, gnt_b, sel, busy);
            end
        end
    end

    task automatic check_out();
        exp_t e;
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $error("FAIL scoreboard: observed empty queue, required one pending expectation");
        end else begin
            e = sb.pop_front();
            assert ({gnt_a, gnt_b, sel, burst_cnt, y_out} === {e.ga, e.gb, e.sel, e.cnt, e.y})
            else begin
                mismatched++;
                $error("FAIL %s: observed ga=%b gb=%b sel=%b cnt=%0d y=%b, required ga=%b gb=%b sel=%b cnt=%0d y=%b",
                       e.tag, gnt_a, gnt_b, sel, burst_cnt, y_out, e.ga, e.gb, e.sel, e.cnt, e.y);
            end
        end
    endtask

    // Drive one cycle of stimulus, queue what the next edge must produce, then compare.
    task automatic step(input logic r, input logic ra, input logic rb, input logic ai, input logic bi,
                        input logic ega, input logic egb, input logic esel, input int ecnt,
                        input string tag);
        exp_t e;
        @(negedge clk);
        rst   = r;
        req_a = ra;
        req_b = rb;
        a_in  = ai;
        b_in  = bi;
        e.tag = tag;
        e.ga  = ega;
        e.gb  = egb;
        e.sel = esel;
        e.cnt = CNT_W'(ecnt);
        e.y   = esel ? bi : ai;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        #100000;
        mismatched++;
        $display("FAIL watchdog: observed no completion by 100000, required finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        logic own_a;
        int   cnt;
        rst   = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        a_in  = 1'b0;
        b_in  = 1'b0;

        // Reset held with both requesting
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, "rst0");
        started = 1'b1;
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, "rst1");

        // Release into continuous contention; first edge grants A
        for (int i = 0; i < 12; i++) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
            own_a = (i % 5) < 4;
            cnt   = own_a ? (i % 5) : 0;
`else
            own_a = ((i / 4) % 2) == 0;
            cnt   = i % 4;
`endif
            step(0, 1, 1, 0, 0, own_a, !own_a, !own_a, cnt, "contend");
        end

        // Single requester, burst wraps without gaps
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "rst2");
        for (int i = 0; i < 10; i++)
            step(0, 1, 0, 1, 0, 1, 0, 0, i % 4, "single");
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, "drop");
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, "idle_a");

        // Early release hands straight to B
        step(0, 1, 0, 0, 0, 1, 0, 0, 0, "ho_a0");
        step(0, 1, 1, 0, 0, 1, 0, 0, 1, "ho_a1");
        step(0, 0, 1, 0, 0, 0, 1, 1, 0, "handover");

        // Data path in OWN_B, then mid-burst reset
        step(0, 0, 1, 1, 0, 0, 1, 1, 1, "dp_b");
        step(0, 0, 1, 1, 0, 0, 1, 1, 2, "b_cnt2");
        step(1, 1, 1, 1, 0, 0, 0, 0, 0, "mid_rst");

        // sel holds in IDLE; switch from B to A flips y_out
        step(0, 0, 1, 1, 0, 0, 1, 1, 0, "own_b");
        step(0, 0, 0, 0, 1, 0, 0, 1, 0, "idle_sel_b");
        step(0, 0, 1, 1, 0, 0, 1, 1, 0, "own_b2");
        step(0, 1, 0, 1, 0, 1, 0, 0, 0, "dp_a");

        // Tie from IDLE after A was last owner
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle2");
`ifdef MUX_ARB_FIXED_PRIO_EN
        step(0, 1, 1, 0, 0, 1, 0, 0, 0, "tie");
        step(0, 0, 1, 0, 0, 0, 1, 1, 0, "to_b");
        step(0, 1, 1, 0, 0, 1, 0, 0, 0, "preempt");
`else
        step(0, 1, 1, 0, 0, 0, 1, 1, 0, "tie");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
